// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and types for the video RAM arbiter
//
// Default sizes (NREQ clients, AW address bits, DW data bits), the slot state
// encoding and the read-owner tag that follows a read through the RAM latency.
package vram_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 17;
    localparam int DW   = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PIX,
        S_CLI
    } state_t;

    // Owner of the read currently inside the RAM: none, the pixel path, or a client index.
    typedef struct packed {
        logic       valid;
        logic       pix;
        logic [7:0] idx;
    } owner_t;

    localparam owner_t OWNER_NONE = '0;

endpackage

// File: rtl/vram_arbiter_rr.sv
// rtl/vram_arbiter_rr.sv - round-robin picker with its rotating pointer
//
// Ports:
//   clk_100MHz, reset : clock, asynchronous active-high reset
//   eligible [N]      : requests that may be served this cycle
//   advance           : the selection is being consumed, move ptr past it
//   sel [N]           : one-hot selection, first eligible at or after ptr
//   sel_idx           : binary index of sel
//   any               : sel is non-zero
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic [N-1:0]  eligible,
    input  logic          advance,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] sel_idx,
    output logic          any
);

    logic [IW-1:0] ptr_q;
    int            cand;

    // Scan N candidates starting at ptr, wrapping; the first eligible one wins.
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!any && eligible[cand]) begin
                any       = 1'b1;
                sel[cand] = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && any) begin
            ptr_q <= (int'(sel_idx) == N - 1) ? '0 : sel_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter: pixel fetch priority, clients round-robin
//
// Optional feature macro: VBLANK_WRITES_EN (client writes only eligible while video_on=0).
//
// Ports:
//   clk_100MHz, reset   : clock, asynchronous active-high reset
//   p_tick, video_on    : pixel tick and display-area flag from the timing generator
//   pix_addr            : pixel read address, used when p_tick && video_on
//   pix_data, pix_valid : fetched pixel and its one-cycle update strobe
//   req, we             : per-client request (held until gnt) and write enable
//   addr, wdata         : packed client address / write data, client i at [i*W +: W]
//   gnt                 : one-hot grant pulse, coincides with the client's RAM cycle
//   rdata, rvalid       : client read data and one-hot valid
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata : RAM port (1-cycle read latency)
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int NREQ = vram_pkg::NREQ,
    parameter int AW   = vram_pkg::AW,
    parameter int DW   = vram_pkg::DW
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             p_tick,
    input  logic             video_on,
    input  logic [AW-1:0]    pix_addr,
    output logic [DW-1:0]    pix_data,
    output logic             pix_valid,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [DW-1:0]    rdata,
    output logic [NREQ-1:0]  rvalid,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] sel;
    logic [IW-1:0]   sel_idx;
    logic            any_sel;
    logic            advance;
    logic [IW-1:0]   cli_idx_q;
    owner_t          tag_q;

    // A client whose grant is on the bus this cycle still shows req (it drops
    // it on seeing gnt), so it is masked to avoid a duplicate access.
`ifdef VBLANK_WRITES_EN
    // Writes wait for blanking; a blocked writer is simply skipped so the
    // pointer keeps rotating for everyone else.
    assign eligible = req & ~gnt & ~(we & {NREQ{video_on}});
`else
    assign eligible = req & ~gnt;
`endif

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .eligible   (eligible),
        .advance    (advance),
        .sel        (sel),
        .sel_idx    (sel_idx),
        .any        (any_sel)
    );

    // Next slot: pixel fetch first, then any eligible client, else idle.
    always_comb begin
        state_d = S_IDLE;
        advance = 1'b0;
        if (p_tick && video_on) begin
            state_d = S_PIX;
        end else if (any_sel) begin
            state_d = S_CLI;
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM port and grant are registered alongside the state so they are
    // valid for exactly the slot cycle.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cli_idx_q <= '0;
        end else begin
            gnt    <= advance ? sel : '0;
            ram_en <= (state_d != S_IDLE);
            ram_we <= 1'b0;
            case (state_d)
                S_PIX: begin
                    ram_addr <= pix_addr;
                end
                S_CLI: begin
                    ram_we    <= we[sel_idx];
                    ram_addr  <= addr[int'(sel_idx)*AW +: AW];
                    ram_wdata <= wdata[int'(sel_idx)*DW +: DW];
                    cli_idx_q <= sel_idx;
                end
                default: ;
            endcase
        end
    end

    // The tag is loaded on the edge where the RAM samples the read; the data
    // is on ram_rdata for the following edge, where it is routed to its owner.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tag_q     <= OWNER_NONE;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            pix_valid <= 1'b0;
            rvalid    <= '0;
            if (tag_q.valid) begin
                if (tag_q.pix) begin
                    pix_data  <= ram_rdata;
                    pix_valid <= 1'b1;
                end else begin
                    rdata  <= ram_rdata;
                    rvalid <= NREQ'(1) << tag_q.idx;
                end
            end

            tag_q <= OWNER_NONE;
            if (state_q == S_PIX) begin
                tag_q <= '{valid: 1'b1, pix: 1'b1, idx: 8'd0};
            end else if (state_q == S_CLI && !ram_we) begin
                tag_q <= '{valid: 1'b1, pix: 1'b0, idx: 8'(cli_idx_q)};
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the VGA pixel-fetch path and NREQ game-logic clients (bird, pipes, score writers). Pixel fetch has hard priority on every pixel tick inside the display area. Clients share all remaining 100 MHz cycles round-robin. It sits between the 640x480 timing generator (p_tick, video_on) and the RAM macro.

## Interface
- NREQ, 3, number of client ports
- AW, 17, RAM address width
- DW, 12, RAM data width (4:4:4 RGB)

- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high
- p_tick  in  1  25 MHz pixel tick, high 1 of 4 cycles
- video_on  in  1  display-area flag from timing generator
- pix_addr  in  AW  pixel read address, valid when p_tick && video_on
- pix_data  out  DW  fetched pixel
- pix_valid  out  1  pix_data updated this cycle
- req  in  NREQ  client request, held until gnt
- we  in  NREQ  per-client write enable
- addr  in  NREQ*AW  client addresses, client i at [i*AW +: AW]
- wdata  in  NREQ*DW  client write data, same packing as addr
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- rdata  out  DW  client read data
- rvalid  out  NREQ  one-hot, read data valid for client i
- ram_en, ram_we  out  1 each  RAM port control
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, 1-cycle latency

## Operation
- The FSM has three states: S_IDLE (no access), S_PIX (pixel slot), S_CLI (client slot). The next state is chosen every cycle, and each state lasts exactly one cycle.
- Priority for the next cycle:
  - p_tick && video_on -> S_PIX.
  - Otherwise any eligible req -> S_CLI.
  - Otherwise S_IDLE.
- Client selection: round-robin starting at ptr.
  - The first asserted req at index ≥ ptr wins, wrapping at NREQ.
  - After a grant, ptr = granted index + 1, mod NREQ.
  - ptr is unchanged in S_PIX and S_IDLE.
- In S_PIX:
  - ram_en=1, ram_we=0, ram_addr=pix_addr.
- In S_CLI:
  - ram_en=1, ram_we=we[i], ram_addr/ram_wdata taken from client i.
  - gnt[i]=1 in the same cycle.
- Reads:
  - The owner of each read is recorded in a 1-deep tag register.
  - The cycle after a read: rdata/pix_data capture ram_rdata, and rvalid[i] or pix_valid pulses for one cycle.
  - Writes produce no rvalid.
- pix_data holds its value between fetches.
- Client handshake: req, we, addr and wdata must stay stable until gnt. Dropping req before gnt is legal and results in no access.
- A pixel slot and a client request in the same cycle: the pixel slot wins and the client waits. The client is served no later than the next non-pixel cycle if it is first in round-robin order.
- Worst-case client wait:
  - Active video: NREQ client slots plus the pixel slots interleaved among them.
  - Blanking: NREQ cycles.

## Timing
- Reset values: state S_IDLE, ptr 0, gnt 0, rvalid 0, pix_valid 0, pix_data 0, rdata 0, ram_en 0, ram_we 0, read tag cleared.
- Slot decision: registered. Inputs sampled at clock edge N drive ram_* and gnt during cycle N+1.
- Read latency: pix_valid/rvalid are asserted at N+2, relative to the sampling edge N.
- Reset asserted mid-operation:
  - Any in-flight read is discarded; no rvalid/pix_valid follows.
  - Outputs return to reset values immediately (asynchronous).
- After reset deasserts, the first access can start on the second edge.

## Configuration
- VBLANK_WRITES_EN
  - Defined: a client with we=1 is eligible only while video_on=0. Writes are deferred to blanking (tear-free). Reads stay eligible at all times. A held write request does not block round-robin progress for other clients.
  - Undefined: all client requests are eligible in any non-pixel cycle.

## Structure
- Package vram_pkg holds:
  - Default constants NREQ, AW, DW.
  - state_t enum {S_IDLE, S_PIX, S_CLI}.
  - owner_t tag (pixel, client index, none).
- Sub-module rr_arbiter: round-robin picker with its ptr register. It takes the eligible vector and an advance strobe, and returns a one-hot selection. vram_arbiter instantiates it once.

## Test plan
- Reset mid-read: reset during an S_CLI read cycle -> no rvalid at N+2; all outputs 0; ptr=0.
- Pixel priority: p_tick=1, video_on=1, pix_addr=0x00100, req=3'b001 -> the next cycle is S_PIX with ram_addr=0x00100. gnt[0] comes one cycle later. pix_valid and rvalid[0] come in successive cycles.
- Round-robin fairness: req=3'b111 held with video_on=0 -> grant sequence 001, 010, 100, 001. Each client is served exactly once per 3 cycles.
- Write then read: client 1 writes 0xABC to 0x01234, then reads 0x01234 -> rdata=0xABC with rvalid=3'b010 two edges after the read sample.
- VBLANK_WRITES_EN defined: client 2 we=1 during video_on=1 -> no gnt until video_on falls. A concurrent client 0 read is still granted.
- Idle: req=0 and video_on=0 -> ram_en stays 0 and state remains S_IDLE.
